// File: rtl/sprite_layer.sv
// Sprite overlay stage for the VGA pixel chain. It composites up to NUM_SPRITES
// fixed-priority sprites from a shared ROM and latches per-frame collisions against sprite 0.
module sprite_layer #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_W       = 16,
  parameter int          SPR_H       = 32,
  parameter int          ROM_AW      = 11,
  parameter int          ROM_LAT     = 0,
  parameter logic [23:0] TRANSP      = 24'h00FFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blnk_in,
  input  logic [23:0]                   rgb_in,
  input  logic [NUM_SPRITES*10-1:0]     spr_x,
  input  logic [NUM_SPRITES*9-1:0]      spr_y,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_dir,
  input  logic [NUM_SPRITES*ROM_AW-1:0] spr_base,
  input  logic [23:0]                   rom_data,
  output logic [ROM_AW-1:0]             rom_addr,
  output logic [9:0]                    hcount_out,
  output logic [9:0]                    vcount_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          blnk_out,
  output logic [23:0]                   rgb_out,
  output logic [NUM_SPRITES-1:0]        collision
);

  localparam int NS = NUM_SPRITES;
  localparam int L  = ROM_LAT + 2;

  typedef struct packed {
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blnk;
    logic [23:0] rgb;
    logic        hit;
  } stage_t;

  typedef struct packed {
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blnk;
    logic [23:0] rgb;
  } out_t;

  logic [NS-1:0]     hit;
  logic [9:0]        dx   [NS];
  logic [9:0]        dy   [NS];
  logic [9:0]        col  [NS];
  logic [ROM_AW-1:0] addr [NS];

  stage_t            pipe_d [L-1];
  stage_t            pipe_q [L-1];
  out_t              out_d, out_q;
  logic [ROM_AW-1:0] rom_addr_d, rom_addr_q;
  logic [NS-1:0]     pend_d, pend_q, coll_d, coll_q, new_coll;
  logic              vs_q;

  // Bounds use 11-bit sums so a sprite hanging past column 1023 clips instead of wrapping.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      dx[i]   = hcount_in - spr_x[10*i +: 10];
      dy[i]   = vcount_in - {1'b0, spr_y[9*i +: 9]};
      col[i]  = spr_dir[i] ? 10'(SPR_W - 1) - dx[i] : dx[i];
      addr[i] = spr_base[ROM_AW*i +: ROM_AW] + ROM_AW'(32'(dy[i]) * SPR_W) + ROM_AW'(col[i]);
      hit[i]  = spr_en[i]
             && ({1'b0, hcount_in} >= {1'b0, spr_x[10*i +: 10]})
             && ({1'b0, hcount_in} <  {1'b0, spr_x[10*i +: 10]} + 11'(SPR_W))
             && ({1'b0, vcount_in} >= {2'b00, spr_y[9*i +: 9]})
             && ({1'b0, vcount_in} <  {2'b00, spr_y[9*i +: 9]} + 11'(SPR_H));
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rom_addr_d = rom_addr_q;
    for (int i = NS - 1; i >= 0; i--) begin
      if (hit[i]) rom_addr_d = addr[i];
    end

    pipe_d[0].hcount = hcount_in;
    pipe_d[0].vcount = vcount_in;
    pipe_d[0].hsync  = hsync_in;
    pipe_d[0].vsync  = vsync_in;
    pipe_d[0].blnk   = blnk_in;
    pipe_d[0].rgb    = rgb_in;
    pipe_d[0].hit    = |hit;
    for (int k = 1; k < L - 1; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_comb begin
    out_d.hcount = pipe_q[L-2].hcount;
    out_d.vcount = pipe_q[L-2].vcount;
    out_d.hsync  = pipe_q[L-2].hsync;
    out_d.vsync  = pipe_q[L-2].vsync;
    out_d.blnk   = pipe_q[L-2].blnk;
    if (pipe_q[L-2].blnk)                           out_d.rgb = 24'h000000;
    else if (pipe_q[L-2].hit && rom_data != TRANSP) out_d.rgb = rom_data;
    else                                            out_d.rgb = pipe_q[L-2].rgb;
  end

  // Bounding-box overlap with sprite 0; a hit on the vsync edge belongs to the next frame.
  always_comb begin
    new_coll = '0;
    if (!blnk_in && hit[0]) new_coll = hit & ({NS{1'b1}} << 1);
    if (vsync_in && !vs_q) begin
      coll_d = pend_q;
      pend_d = new_coll;
    end else begin
      coll_d = coll_q;
      pend_d = pend_q | new_coll;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the delay line is small and must come out of reset clean, so it is reset like plain flops.
      for (int k = 0; k < L - 1; k++) pipe_q[k] <= '0;
      out_q      <= '0;
      rom_addr_q <= '0;
      pend_q     <= '0;
      coll_q     <= '0;
      vs_q       <= 1'b0;
    end else begin
      for (int k = 0; k < L - 1; k++) pipe_q[k] <= pipe_d[k];
      out_q      <= out_d;
      rom_addr_q <= rom_addr_d;
      pend_q     <= pend_d;
      coll_q     <= coll_d;
      vs_q       <= vsync_in;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign blnk_out   = out_q.blnk;
  assign rgb_out    = out_q.rgb;
  assign collision  = coll_q;

endmodule
